// File: rtl/shift_input_conditioner.sv
// shift_input_conditioner: sync + debounce of up/down/brake inputs into one-hot shift pulses and a brake level.
// Optional auto-repeat of a held paddle is compiled in with `define SHIFT_AUTOREPEAT_EN.
module shift_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic up_raw,
  input  logic down_raw,
  input  logic brake_raw,
  output logic shift_up,
  output logic shift_down,
  output logic brake,
  output logic conflict
);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("shift_input_conditioner: parameter out of range");
  end
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [2:0] raw, s1, s2, stable, hit;
  logic [CNT_W-1:0] cnt [3];
  logic rise_up, rise_dn, rpt;
  assign raw = {brake_raw, down_raw, up_raw};
  // hit marks the edge on which a channel's debounced level flips
  always_comb begin
    for (int i = 0; i < 3; i++) hit[i] = (s2[i] != stable[i]) && (cnt[i] == DB_MAX);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      stable <= stable ^ hit;
      for (int i = 0; i < 3; i++) cnt[i] <= (s2[i] == stable[i] || hit[i]) ? '0 : cnt[i] + CNT_W'(1);
    end
  end
  assign rise_up = hit[0] & s2[0];
  assign rise_dn = hit[1] & s2[1];
  assign brake   = stable[2];
`ifdef SHIFT_AUTOREPEAT_EN
  logic [CNT_W-1:0] rpt_cnt, rpt_lim;
  logic rpt_rep, rpt_act;
  // one shared counter: repetition only runs while exactly one paddle is held and no new press is landing
  assign rpt_act = (stable[0] ^ stable[1]) & ~rise_up & ~rise_dn;
  assign rpt_lim = rpt_rep ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
  assign rpt     = rpt_act && (rpt_cnt == rpt_lim);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt <= '0;
      rpt_rep <= 1'b0;
    end else begin
      rpt_cnt <= (!rpt_act || rpt) ? '0 : rpt_cnt + CNT_W'(1);
      rpt_rep <= rpt_act && (rpt_rep || rpt);
    end
  end
`else
  assign rpt = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_up   <= 1'b0;
      shift_down <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      shift_up   <= (rise_up & ~rise_dn) | (rpt & stable[0]);
      shift_down <= (rise_dn & ~rise_up) | (rpt & stable[1]);
      conflict   <= rise_up & rise_dn;
    end
  end
endmodule

// File: doc/shift_input_conditioner.md
# shift_input_conditioner

- Front-end for the gearbox selector.
- Takes raw, asynchronous lever/pedal inputs (up paddle, down paddle, brake pedal) and synchronises and debounces each one.
- Produces the single-cycle `shift_up`/`shift_down` pulses and the clean `brake` level that the gear-state FSM consumes directly.
- Guarantees at most one shift pulse per physical press, and suppresses contradictory simultaneous requests.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a debounced level changes; legal range 2..65535.
- `CNT_W`, 16: width of the debounce and repeat counters; must hold the larger of `DEBOUNCE_CYCLES` and `REPEAT_DELAY`.
- `REPEAT_DELAY`, 64: cycles from the first pulse to the first auto-repeat pulse; used only with `SHIFT_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, 16: cycles between subsequent auto-repeat pulses; used only with `SHIFT_AUTOREPEAT_EN`.

Ports:
- `clk` input 1: single clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `up_raw` input 1: raw up paddle, asynchronous, active high.
- `down_raw` input 1: raw down paddle, asynchronous, active high.
- `brake_raw` input 1: raw brake switch, asynchronous, active high.
- `shift_up` output 1: registered one-cycle pulse per accepted up press.
- `shift_down` output 1: registered one-cycle pulse per accepted down press.
- `brake` output 1: registered debounced brake level.
- `conflict` output 1: registered one-cycle pulse when up and down rise together.

## Operation

Per-channel path (up, down, brake are identical):
- Two-flop synchroniser `s1 -> s2`.
- Debounce unit holding `stable` and `cnt`:
  - `s2 == stable`: `cnt <= 0`.
  - `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `cnt <= 0`.
- Any single-cycle return of `s2` to `stable` restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` never propagate.

Outputs:
- `brake` equals the brake channel's `stable`.
- Rise events: `rise_up`/`rise_dn` are asserted on the edge where the channel's `stable` goes 0->1. Falling edges produce nothing.
- Arbitration, evaluated on the same edge:
  - `rise_up` and not `rise_dn` -> `shift_up=1`.
  - `rise_dn` and not `rise_up` -> `shift_down=1`.
  - Both rise -> `shift_up=0`, `shift_down=0`, `conflict=1`.
- A press on one paddle while the other is already debounced-high still pulses normally.
- Every pulse output is high for exactly one cycle. `shift_up` and `shift_down` are never high in the same cycle.

Reset:
- Reset state: all `s1`, `s2`, `stable`, `cnt` and repeat state are 0, and all outputs are 0.
- A button already held when `reset_n` releases is treated as a new press and pulses after full latency.
- `reset_n` low mid-count: discard all state immediately; no pending pulse survives reset.

## Timing

- Raw input changes and holds before rising edge N:
  - `s1` updates at edge N.
  - `s2` updates at edge N+1.
  - `stable`, `brake`, `shift_*` and `conflict` update at edge N+1+`DEBOUNCE_CYCLES`.
- Pulse outputs return to 0 on the following edge.
- Release latency is the same as press latency. Release produces no output pulse.
- Outputs depend on no combinational path from inputs.

## Configuration

`SHIFT_AUTOREPEAT_EN` defined (auto-repeat compiled in):
- While one paddle's `stable` stays 1 and the other paddle's `stable` is 0, the block emits a repeat pulse on that paddle's output:
  - first repeat `REPEAT_DELAY` cycles after the initial pulse;
  - then one every `REPEAT_PERIOD` cycles.
- Releasing the paddle, or the other paddle going debounced-high, stops repetition and clears the repeat counter.
- Repeat pulses obey the same one-hot rule and never coincide with `conflict`.

`SHIFT_AUTOREPEAT_EN` undefined (compiled out): exactly one pulse per press; the repeat logic and `REPEAT_*` parameters are unused.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=4`.
- Clean press: `up_raw` 1 before edge 10, held 30 cycles -> `shift_up` high only in the cycle after edge 15; `shift_down`, `conflict`, `brake` stay 0.
- Bounce: `down_raw` toggles every 2 cycles for 12 cycles, then holds 1 from before edge M -> exactly one `shift_down` pulse, after edge M+5; no earlier pulses.
- Conflict: `up_raw` and `down_raw` both 1 before edge 20 -> `conflict` pulses after edge 25; `shift_up` and `shift_down` stay 0 throughout.
- Brake:
  - `brake_raw` high for 3 cycles -> `brake` stays 0.
  - `brake_raw` then held from before edge 40 -> `brake`=1 after edge 45; no shift pulses.
  - `brake_raw` released before edge 60 -> `brake`=0 after edge 65.
- Reset mid-count:
  - `up_raw` 1 before edge 10, `reset_n` low at edge 12..14 -> all outputs 0 during reset.
  - With `up_raw` still 1, `shift_up` pulses once, at full latency counted from reset release.
  - With `up_raw` low at release, no pulse.
- Auto-repeat, `REPEAT_DELAY=8`, `REPEAT_PERIOD=4`, `up_raw` held 40 cycles:
  - macro defined -> `shift_up` pulses at T, T+8, T+12, T+16, …, stopping after release debounces;
  - macro undefined -> a single pulse at T.
